// File: rtl/mult6x6_seq_pkg.sv
// mult6x6_seq_pkg
//   Shared definitions for the sequenced 6x6 multiplier: FSM state
//   encoding and the fixed operand / slice / product widths.
package mult6x6_seq_pkg;

    localparam int OPW = 6;   // operand width
    localparam int SLW = 3;   // slice width fed to the 3x3 array
    localparam int PW  = 12;  // product width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult6x6_seq_mult3x3.sv
// mult3x3
//   Combinational 3x3 unsigned array multiplier with bitwise ports.
//   Ports:
//     a0..a2  in  multiplicand bits (a0 = LSB)
//     b0..b2  in  multiplier bits (b0 = LSB)
//     p0..p5  out product bits (p0 = LSB)
module mult3x3 (
    output logic p0,
    output logic p1,
    output logic p2,
    output logic p3,
    output logic p4,
    output logic p5,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic b0,
    input  logic b1,
    input  logic b2
);

    logic [2:0] av;
    logic [5:0] row0;
    logic [5:0] row1;
    logic [5:0] row2;
    logic [5:0] prod;

    assign av   = {a2, a1, a0};
    // One AND row per multiplier bit, each pre-shifted to its weight.
    assign row0 = {3'b000, av & {3{b0}}};
    assign row1 = {2'b00,  av & {3{b1}}, 1'b0};
    assign row2 = {1'b0,   av & {3{b2}}, 2'b00};
    assign prod = row0 + row1 + row2;

    assign {p5, p4, p3, p2, p1, p0} = prod;

endmodule

// File: rtl/mult6x6_seq.sv
// mult6x6_seq
//   Sequenced 6x6 unsigned multiplier. One shared mult3x3 array is
//   time-multiplexed over the four 3-bit partial products, which are
//   accumulated into a 12-bit sum.
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. in_ready depends only on state, out_valid likewise;
//   neither looks at the opposite side's valid/ready.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     in_valid   in   operand pair a/b valid
//     in_ready   out  operands accepted (IDLE only)
//     a, b       in   6-bit unsigned operands
//     out_valid  out  p holds a completed product (DONE)
//     out_ready  in   consumer takes the product
//     p          out  12-bit registered product
//     busy       out  high in MUL or DONE
module mult6x6_seq
    import mult6x6_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] p,
    output logic          busy
);

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      step;
    logic [OPW-1:0]  a_r;
    logic [OPW-1:0]  b_r;
    logic [PW-1:0]   acc;

    logic [SLW-1:0]  a_sl;
    logic [SLW-1:0]  b_sl;
    logic [5:0]      pp;
    logic [PW-1:0]   pp_ext;
    logic [PW-1:0]   pp_sh;
    logic [PW-1:0]   acc_sum;

    // step[0] picks the a-slice, step[1] the b-slice.
    assign a_sl = step[0] ? a_r[5:3] : a_r[2:0];
    assign b_sl = step[1] ? b_r[5:3] : b_r[2:0];

    mult3x3 u_mult (
        .p0 (pp[0]),
        .p1 (pp[1]),
        .p2 (pp[2]),
        .p3 (pp[3]),
        .p4 (pp[4]),
        .p5 (pp[5]),
        .a0 (a_sl[0]),
        .a1 (a_sl[1]),
        .a2 (a_sl[2]),
        .b0 (b_sl[0]),
        .b1 (b_sl[1]),
        .b2 (b_sl[2])
    );

    assign pp_ext = {6'b000000, pp};

    // Weight of the partial product is 3*(i+j): 0, 3, 3, 6.
    always_comb begin
        pp_sh = pp_ext;
        case (step)
            2'd0:    pp_sh = pp_ext;
            2'd1:    pp_sh = pp_ext << 3;
            2'd2:    pp_sh = pp_ext << 3;
            default: pp_sh = pp_ext << 6;
        endcase
    end

    // 63*63 = 3969 fits in 12 bits, so no carry-out is needed.
    assign acc_sum = acc + pp_sh;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)       state_nxt = ST_MUL;
            ST_MUL:  if (step == 2'd3)   state_nxt = ST_DONE;
            ST_DONE: if (out_ready)      state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            step  <= 2'd0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            p     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r  <= a;
                        b_r  <= b;
                        acc  <= '0;
                        step <= 2'd0;
                    end
                end
                ST_MUL: begin
                    acc  <= acc_sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) p <= acc_sum;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mult6x6_seq.sv
module tb_mult6x6_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] p;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_xfer = 0;
  logic [11:0] exp_q[$];

  mult6x6_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: inputs change at posedge+1, so the negedge sees the values
  // the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(12'(a) * 12'(b));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        logic [11:0] e;
        n_xfer++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_out: p=%0d but no product expected", p);
        end else begin
          e = exp_q.pop_front();
          if (p !== e) begin
            bad++;
            $display("FAIL sb_product: p=%0d expected=%0d", p, e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for in_ready, presents the pair for exactly one accept edge.
  task automatic send(input logic [5:0] av, input logic [5:0] bv, input logic hold);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    int guard;
    guard = 0;
    while (!out_valid && guard < 100) begin
      tick();
      guard++;
    end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL %s_timeout: out_valid=0 required=1", name);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%0b want=0", out_valid); end
    total++; if (p !== 12'd0)        begin bad++; $display("FAIL reset_p: got=%0d want=0", p); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got=%0b want=0", busy); end
  endtask

  // Checks out_valid appears exactly on the 4th edge after accept.
  task automatic test_latency(input logic [5:0] av, input logic [5:0] bv, input logic [11:0] ep);
    out_ready = 1'b1;
    send(av, bv, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if (out_valid !== (k == 4)) begin
        bad++;
        $display("FAIL latency_%0d: out_valid=%0b after edge %0d want=%0b", av, out_valid, k, (k == 4));
      end
    end
    total++;
    if (p !== ep) begin bad++; $display("FAIL latency_p: p=%0d want=%0d", p, ep); end
    tick();
  endtask

  task automatic test_max_acc();
    logic [11:0] acc_exp [4];
    acc_exp[0] = 12'd49;
    acc_exp[1] = 12'd441;
    acc_exp[2] = 12'd833;
    acc_exp[3] = 12'd3969;
    out_ready = 1'b1;
    send(6'd63, 6'd63, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (dut.acc !== acc_exp[k]) begin
        bad++;
        $display("FAIL max_acc_step%0d: acc=%0d want=%0d", k, dut.acc, acc_exp[k]);
      end
    end
    total++;
    if (p !== 12'hF81) begin bad++; $display("FAIL max_p: p=%0d want=3969", p); end
    tick();
  endtask

  task automatic test_ignore_in_valid();
    out_ready = 1'b1;
    send(6'd45, 6'd27, 1'b1);
    a = 6'd1;
    b = 6'd1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL ignore_in_ready_%0d: got=%0b want=0", k, in_ready); end
    end
    total++;
    if (p !== 12'd1215) begin bad++; $display("FAIL ignore_p: p=%0d want=1215", p); end
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL ignore_back_idle: in_ready=%0b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL ignore_second_accept: in_ready=%0b want=0", in_ready); end
    wait_out_valid("ignore2");
    total++;
    if (p !== 12'd1) begin bad++; $display("FAIL ignore_second_p: p=%0d want=1", p); end
    tick();
  endtask

  task automatic test_backpressure_hold();
    out_ready = 1'b0;
    send(6'd7, 6'd56, 1'b0);
    wait_out_valid("hold");
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || p !== 12'd392) begin
        bad++;
        $display("FAIL hold_%0d: out_valid=%0b p=%0d want 1/392", k, out_valid, p);
      end
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_single_xfer: out_valid=%0b want=0", out_valid); end
    total++;
    if (p !== 12'd392) begin bad++; $display("FAIL hold_p_kept: p=%0d want=392", p); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    send(6'd63, 6'd5, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_in_ready: got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got=%0b want=0", out_valid); end
    total++; if (dut.acc !== 12'd0)  begin bad++; $display("FAIL midrst_acc: got=%0d want=0", dut.acc); end
    total++; if (p !== 12'd0)        begin bad++; $display("FAIL midrst_p: got=%0d want=0", p); end
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_pulse_%0d: out_valid=%0b want=0", k, out_valid); end
    end
    send(6'd3, 6'd3, 1'b0);
    wait_out_valid("midrst_next");
    total++;
    if (p !== 12'd9) begin bad++; $display("FAIL midrst_next_p: p=%0d want=9", p); end
    tick();
  endtask

  task automatic test_exhaustive();
    int acc0;
    int xfer0;
    int guard;
    bit drv_done;
    acc0 = n_acc;
    xfer0 = n_xfer;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++)
          for (int j = 0; j < 64; j++)
            send(i[5:0], j[5:0], 1'b0);
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 100) begin
      tick();
      guard++;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL exh_drain: pending=%0d want=0", exp_q.size()); end
    total++;
    if (n_acc - acc0 != 4096) begin bad++; $display("FAIL exh_accepts: got=%0d want=4096", n_acc - acc0); end
    total++;
    if (n_xfer - xfer0 != 4096) begin bad++; $display("FAIL exh_transfers: got=%0d want=4096", n_xfer - xfer0); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;
    test_reset();
    test_latency(6'd0, 6'd0, 12'd0);
    test_max_acc();
    test_ignore_in_valid();
    test_backpressure_hold();
    test_reset_midflight();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
